// File: rtl/dp_pkg.sv
// Shared definitions for the partial-sum buffer: width derivations,
// drain FSM state encoding and skid FIFO depth.
package dp_pkg;

    typedef enum logic [1:0] {
        DRN_IDLE  = 2'd0,
        DRN_READ  = 2'd1,
        DRN_FLUSH = 2'd2
    } drain_state_e;

    function automatic int dp_aw(input int addr_w, input int log_nb);
        return addr_w + log_nb;
    endfunction

    function automatic int dp_dw(input int coe_w, input int num_poly);
        return coe_w * num_poly * 2;
    endfunction

    // Room for every read in flight plus output register slack.
    function automatic int dp_skid_depth(input int bram_dly);
        return bram_dly + 3;
    endfunction

endpackage

// File: rtl/dp_psum_skid_fifo.sv
// Synchronous FIFO with a registered output stage and occupancy output.
// Ports: push_i/data_i write side; valid_o/ready_i/data_o read side;
// count_o = stored words including the output register.
module dp_psum_skid_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          vld_q;
    logic [W-1:0]  out_q;
    logic          load;
    logic          pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Output register refills whenever it is empty or being consumed.
    assign load = !vld_q || ready_i;
    assign pop  = load && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
            out_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= nxt(wr_q);
            end
            if (pop) begin
                rd_q  <= nxt(rd_q);
                out_q <= mem_q[rd_q];
            end
            if (load) begin
                vld_q <= pop;
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop);
        end
    end

    assign valid_o = vld_q;
    assign data_o  = out_q;
    assign count_o = cnt_q + CW'(vld_q);

endmodule

// File: rtl/dp_psum_buf.sv
// Ping-pong partial-sum buffer: active bank serves madd psum write/read,
// shadow bank is drained as a ready/valid stream. Optional macro
// DP_PSUM_ZERO_ON_DRAIN_EN clears each shadow word as its read issues.
// Ports: i_madd_nxt_* psum write/read, i_first read masking,
// i_swap/o_swap_rdy/o_active_bank bank control,
// i_drain_start/o_drain_busy/o_drain_* drain stream and done pulse.
module dp_psum_buf
    import dp_pkg::*;
#(
    parameter  int COE_WIDTH         = 35,
    parameter  int ADDR_WIDTH        = 9,
    parameter  int LOG_NUM_BANK      = 3,
    parameter  int NUM_POLY          = 3,
    parameter  int COMMON_BRAM_DELAY = 1,
    localparam int AW = dp_aw(ADDR_WIDTH, LOG_NUM_BANK),
    localparam int DW = dp_dw(COE_WIDTH, NUM_POLY)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_madd_nxt_we,
    input  logic [AW-1:0] i_madd_nxt_wraddr,
    input  logic [DW-1:0] i_madd_nxt_dout,
    input  logic [AW-1:0] i_madd_nxt_rdaddr,
    output logic [DW-1:0] o_madd_nxt_din_psum,
    input  logic          i_first,
    input  logic          i_swap,
    output logic          o_swap_rdy,
    output logic          o_active_bank,
    input  logic          i_drain_start,
    output logic          o_drain_busy,
    output logic          o_drain_valid,
    input  logic          i_drain_ready,
    output logic [DW-1:0] o_drain_data,
    output logic          o_drain_last,
    output logic          o_drain_done
);

    localparam int D     = COMMON_BRAM_DELAY;
    localparam int NW    = 1 << AW;
    localparam int DEPTH = dp_skid_depth(COMMON_BRAM_DELAY);
    localparam int CW    = $clog2(DEPTH + 1);

    drain_state_e       state_q, state_d;
    logic [AW-1:0]      dra_q, dra_d;
    logic               active_q;
    logic               done_q;
    logic               busy;
    logic               issue;
    logic               hs_last;

    logic [D-1:0]       iss_q;
    logic [D-1:0]       lst_q;
    logic [D-1:0]       sel_q;
    logic [D-1:0]       fst_q;

    logic [1:0]         bwe;
    logic [1:0][AW-1:0] bwa;
    logic [1:0][DW-1:0] bwd;
    logic [1:0][AW-1:0] bra;
    logic [1:0][DW-1:0] brd;

    logic [CW-1:0]      fifo_cnt;
    logic               fifo_vld;
    logic [DW:0]        fifo_dout;

    assign busy    = (state_q != DRN_IDLE);
    assign issue   = (state_q == DRN_READ) &&
                     (int'(fifo_cnt) + $countones(iss_q) < DEPTH);
    assign hs_last = fifo_vld && i_drain_ready && fifo_dout[DW];

    // Bank port muxing: active bank follows madd, shadow follows drain.
    always_comb begin
        bwe    = '0;
        bwa[0] = i_madd_nxt_wraddr;
        bwa[1] = i_madd_nxt_wraddr;
        bwd[0] = i_madd_nxt_dout;
        bwd[1] = i_madd_nxt_dout;
        bwe[0] = i_madd_nxt_we && !active_q;
        bwe[1] = i_madd_nxt_we && active_q;
        bra[0] = active_q ? dra_q : i_madd_nxt_rdaddr;
        bra[1] = active_q ? i_madd_nxt_rdaddr : dra_q;
`ifdef DP_PSUM_ZERO_ON_DRAIN_EN
        if (issue) begin
            if (active_q) begin
                bwe[0] = 1'b1;
                bwa[0] = dra_q;
                bwd[0] = '0;
            end else begin
                bwe[1] = 1'b1;
                bwa[1] = dra_q;
                bwd[1] = '0;
            end
        end
`endif
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [DW-1:0] mem [NW];
        logic [DW-1:0] pipe_q [D];

        // Read-first: the read samples the array before the write lands.
        always_ff @(posedge clk) begin
            if (bwe[b]) begin
                mem[bwa[b]] <= bwd[b];
            end
            pipe_q[0] <= mem[bra[b]];
            for (int i = 1; i < D; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign brd[b] = pipe_q[D-1];
    end

    always_comb begin
        state_d = state_q;
        dra_d   = dra_q;
        unique case (state_q)
            DRN_IDLE: begin
                if (i_drain_start) begin
                    state_d = DRN_READ;
                    dra_d   = '0;
                end
            end
            DRN_READ: begin
                if (issue) begin
                    dra_d = dra_q + AW'(1);
                    if (dra_q == '1) begin
                        state_d = DRN_FLUSH;
                    end
                end
            end
            DRN_FLUSH: begin
                if (hs_last) begin
                    state_d = DRN_IDLE;
                end
            end
            default: begin
                state_d = DRN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= DRN_IDLE;
            dra_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dra_q    <= dra_d;
            active_q <= active_q ^ (i_swap && !busy);
            done_q   <= hs_last;
        end
    end

    // Per-read tags travel alongside the RAM read pipeline. The first-mask
    // resets to ones so the psum output is zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_q <= '0;
            lst_q <= '0;
            sel_q <= '0;
            fst_q <= '1;
        end else begin
            iss_q[0] <= issue;
            lst_q[0] <= (dra_q == '1);
            sel_q[0] <= active_q;
            fst_q[0] <= i_first;
            for (int i = 1; i < D; i++) begin
                iss_q[i] <= iss_q[i-1];
                lst_q[i] <= lst_q[i-1];
                sel_q[i] <= sel_q[i-1];
                fst_q[i] <= fst_q[i-1];
            end
        end
    end

    assign o_madd_nxt_din_psum = fst_q[D-1] ? '0 :
                                 (sel_q[D-1] ? brd[1] : brd[0]);

    // Shadow bank cannot change while busy, so select by current bank.
    dp_psum_skid_fifo #(
        .W     (DW + 1),
        .DEPTH (DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (iss_q[D-1]),
        .data_i  ({lst_q[D-1], (active_q ? brd[0] : brd[1])}),
        .ready_i (i_drain_ready),
        .valid_o (fifo_vld),
        .data_o  (fifo_dout),
        .count_o (fifo_cnt)
    );

    assign o_swap_rdy    = !busy;
    assign o_active_bank = active_q;
    assign o_drain_busy  = busy;
    assign o_drain_valid = fifo_vld;
    assign o_drain_data  = fifo_dout[DW-1:0];
    assign o_drain_last  = fifo_dout[DW];
    assign o_drain_done  = done_q;

endmodule

// File: tb/tb_dp_psum_buf.sv
// Scoreboard bench for dp_psum_buf: psum read path, swaps and drains
// under several ready patterns, including reset in the middle of a drain.
module tb_dp_psum_buf;

    localparam int AW  = 12;
    localparam int DW  = 210;
    localparam int NW  = 4096;
    localparam int DLY = 1;

    typedef logic [DW:0] word_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_madd_nxt_we;
    logic [AW-1:0] i_madd_nxt_wraddr;
    logic [DW-1:0] i_madd_nxt_dout;
    logic [AW-1:0] i_madd_nxt_rdaddr;
    logic [DW-1:0] o_madd_nxt_din_psum;
    logic          i_first;
    logic          i_swap;
    logic          o_swap_rdy;
    logic          o_active_bank;
    logic          i_drain_start;
    logic          o_drain_busy;
    logic          o_drain_valid;
    logic          i_drain_ready;
    logic [DW-1:0] o_drain_data;
    logic          o_drain_last;
    logic          o_drain_done;

    dp_psum_buf u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_madd_nxt_we       (i_madd_nxt_we),
        .i_madd_nxt_wraddr   (i_madd_nxt_wraddr),
        .i_madd_nxt_dout     (i_madd_nxt_dout),
        .i_madd_nxt_rdaddr   (i_madd_nxt_rdaddr),
        .o_madd_nxt_din_psum (o_madd_nxt_din_psum),
        .i_first             (i_first),
        .i_swap              (i_swap),
        .o_swap_rdy          (o_swap_rdy),
        .o_active_bank       (o_active_bank),
        .i_drain_start       (i_drain_start),
        .o_drain_busy        (o_drain_busy),
        .o_drain_valid       (o_drain_valid),
        .i_drain_ready       (i_drain_ready),
        .o_drain_data        (o_drain_data),
        .o_drain_last        (o_drain_last),
        .o_drain_done        (o_drain_done)
    );

    always #5 clk = ~clk;

    word_t exp_q[$];
    int    checks     = 0;
    int    failures   = 0;
    int    hs_cnt     = 0;
    int    ready_mode = 0;
    int    stall      = 0;
    int    m_active   = 0;
    int    bank_pat[2];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int p, input int a);
        logic [DW-1:0] v;
        v = DW'(a);
        case (p)
            0: v = DW'(a);
            1: begin
                v = v | (v << 180);
                v[DW-1] = 1'b1;
            end
            2: v = DW'(NW - 1 - a);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Ready pattern: mode 0 always ready, mode 1 toggles with 3-cycle stalls.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            i_drain_ready = 1'b1;
        end else if (stall > 0) begin
            stall--;
            i_drain_ready = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
            stall = 2;
            i_drain_ready = 1'b0;
        end else begin
            i_drain_ready = !i_drain_ready;
        end
    end

    // Monitor: pops expected words on handshakes, checks hold and done.
    logic  held_prev   = 1'b0;
    logic  lasths_prev = 1'b0;
    word_t held_w;

    always @(negedge clk) begin
        word_t w;
        word_t e;
        w = {o_drain_last, o_drain_data};
        if (held_prev) begin
            chk("hold_valid", o_drain_valid, 1);
            chk("hold_data", w, held_w);
        end
        if (lasths_prev || o_drain_done) begin
            chk("done_pulse", o_drain_done, lasths_prev);
        end
        lasths_prev = 1'b0;
        if (rst_n && o_drain_valid && i_drain_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL drain_extra act=%h exp=none", w);
            end else begin
                e = exp_q.pop_front();
                chk("drain_word", w, e);
            end
            lasths_prev = o_drain_last;
        end
        held_prev = rst_n && o_drain_valid && !i_drain_ready;
        held_w    = w;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int p);
        for (int a = 0; a < NW; a++) begin
            i_madd_nxt_we     = 1'b1;
            i_madd_nxt_wraddr = AW'(a);
            i_madd_nxt_dout   = pat(p, a);
            tick();
        end
        i_madd_nxt_we = 1'b0;
        bank_pat[m_active] = p;
    endtask

    task automatic do_swap();
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        m_active = 1 - m_active;
        chk("active_after_swap", o_active_bank, m_active);
    endtask

    task automatic drain(input bit with_swap, input int rmode,
                         input bit busy_swap, input bit rst_mid);
        int sh;
        int base;
        int n;
        ready_mode = rmode;
        if (with_swap) m_active = 1 - m_active;
        sh = 1 - m_active;
        for (int a = 0; a < NW; a++) begin
            exp_q.push_back({(a == NW - 1), pat(bank_pat[sh], a)});
        end
`ifdef DP_PSUM_ZERO_ON_DRAIN_EN
        bank_pat[sh] = 3;
`endif
        base = hs_cnt;
        i_drain_start = 1'b1;
        i_swap = with_swap;
        tick();
        i_drain_start = 1'b0;
        i_swap = 1'b0;
        if (with_swap) chk("swap_with_start", o_active_bank, m_active);
        chk("busy_after_start", o_drain_busy, 1);
        tick();
        tick();
        chk("first_valid_early", o_drain_valid, 0);
        tick();
        chk("first_valid_lat", o_drain_valid, 1);
        if (busy_swap) begin
            i_swap = 1'b1;
            #1;
            chk("swap_rdy_busy", o_swap_rdy, 0);
            tick();
            i_swap = 1'b0;
            chk("active_hold_busy", o_active_bank, m_active);
        end
        if (rst_mid) begin
            n = 0;
            while (hs_cnt - base < 100 && n < 2000) begin
                tick();
                n++;
            end
            chk("reach_word100", (hs_cnt - base >= 100), 1);
            rst_n = 1'b0;
            tick();
            chk("rst_mid_valid", o_drain_valid, 0);
            chk("rst_mid_busy", o_drain_busy, 0);
            rst_n = 1'b1;
            exp_q.delete();
            m_active = 0;
            return;
        end
        n = 0;
        while ((o_drain_busy || exp_q.size() != 0) && n < 20000) begin
            tick();
            n++;
        end
        chk("drain_complete", (!o_drain_busy && exp_q.size() == 0), 1);
        tick();
        tick();
        chk("swap_rdy_idle", o_swap_rdy, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bank_pat[0]       = 3;
        bank_pat[1]       = 3;
        rst_n             = 1'b0;
        i_madd_nxt_we     = 1'b0;
        i_madd_nxt_wraddr = '0;
        i_madd_nxt_dout   = '0;
        i_madd_nxt_rdaddr = '0;
        i_first           = 1'b0;
        i_swap            = 1'b0;
        i_drain_start     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_psum", o_madd_nxt_din_psum, 0);
        chk("rst_valid", o_drain_valid, 0);
        chk("rst_busy", o_drain_busy, 0);
        chk("rst_data", o_drain_data, 0);
        chk("rst_last", o_drain_last, 0);
        chk("rst_done", o_drain_done, 0);
        chk("rst_swap_rdy", o_swap_rdy, 1);
        chk("rst_active", o_active_bank, 0);

        i_madd_nxt_we     = 1'b1;
        i_madd_nxt_wraddr = AW'(5);
        i_madd_nxt_dout   = DW'(32'h1234);
        tick();
        i_madd_nxt_we     = 1'b0;
        i_madd_nxt_rdaddr = AW'(5);
        i_first           = 1'b0;
        tick();
        chk("psum_read", o_madd_nxt_din_psum, 'h1234);
        i_first = 1'b1;
        tick();
        chk("psum_first_zero", o_madd_nxt_din_psum, 0);
        i_first           = 1'b0;
        i_madd_nxt_we     = 1'b1;
        i_madd_nxt_dout   = DW'(32'h5678);
        tick();
        i_madd_nxt_we = 1'b0;
        chk("psum_read_first_old", o_madd_nxt_din_psum, 'h1234);
        tick();
        chk("psum_read_new", o_madd_nxt_din_psum, 'h5678);

        fill(0);
        do_swap();
        drain(1'b0, 0, 1'b0, 1'b0);

        fill(1);
        do_swap();
        drain(1'b0, 1, 1'b0, 1'b0);

        drain(1'b0, 0, 1'b1, 1'b0);
        drain(1'b1, 0, 1'b0, 1'b0);
        drain(1'b0, 0, 1'b0, 1'b1);

        chk("post_rst_active", o_active_bank, 0);
        fill(2);
        do_swap();
        drain(1'b0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
